// File: rtl/serial_adder.sv
// Bit-serial ripple adder: operands accepted over a valid/ready handshake, added
// LSB-first one bit per clock through a single full-adder cell with a registered
// carry, result presented over a second valid/ready handshake.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;

  logic             accept_c;
  logic             load_c;
  logic             release_c;
  logic             last_c;
  logic             bit_s_c;
  logic             bit_c_c;
  logic [WIDTH-1:0] sum_next_c;

  // Ready only in IDLE and never while reset is held.
  assign in_ready = (state_q == IDLE) && rst_n;

  // One-bit full adder on the current LSBs and the registered carry.
  assign bit_s_c = a_sr[0] ^ b_sr[0] ^ carry_q;
  assign bit_c_c = (a_sr[0] & b_sr[0]) | (b_sr[0] & carry_q) | (carry_q & a_sr[0]);

  // Sum shift register after inserting this cycle's bit at the MSB.
  assign sum_next_c = (sum_sr >> 1) | (WIDTH'(bit_s_c) << (WIDTH - 1));

  assign last_c = (cnt_q == CNT_W'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    state_d   = state_q;
    accept_c  = 1'b0;
    load_c    = 1'b0;
    release_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          accept_c = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (last_c) begin
          load_c  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          release_c = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture and per-bit shifting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      sum_sr  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else if (accept_c) begin
      a_sr    <= a;
      b_sr    <= b;
      sum_sr  <= '0;
      carry_q <= cin;
      cnt_q   <= '0;
    end else if (state_q == SHIFT) begin
      a_sr    <= a_sr >> 1;
      b_sr    <= b_sr >> 1;
      sum_sr  <= sum_next_c;
      carry_q <= bit_c_c;
      cnt_q   <= cnt_q + CNT_W'(1);
    end
  end

  // Result registers: loaded on the final bit, held until the next result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else if (load_c) begin
      sum       <= sum_next_c;
      cout      <= bit_c_c;
      out_valid <= 1'b1;
    end else if (release_c) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: WIDTH=8 main instance plus a WIDTH=1 instance.
module tb_serial_adder;

  logic       clk;
  logic       rst_n;

  logic       in_valid,  in_ready,  cin,  out_valid,  out_ready,  cout;
  logic [7:0] a, b, sum;

  logic       in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1;
  logic [0:0] a1, b1, sum1;

  int checks, errors;
  int pushed, popped, abandoned;
  int pushed1, popped1;
  bit rand_mode;

  logic [8:0] q[$];
  logic [1:0] q1[$];

  serial_adder #(.WIDTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Random consumer stalls while enabled.
  initial forever begin
    @(negedge clk);
    if (rand_mode) out_ready = 1'($urandom_range(0, 1));
  end

  // Monitor for the WIDTH=8 result port.
  initial forever begin
    logic [8:0] e;
    @(negedge clk);
    #2;
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_result: got %0h expected none", {cout, sum});
      end else begin
        e = q.pop_front();
        chk("result", 32'({cout, sum}), 32'(e));
        popped++;
      end
    end
  end

  // Monitor for the WIDTH=1 result port.
  initial forever begin
    logic [1:0] e;
    @(negedge clk);
    #2;
    if (rst_n && out_valid1 && out_ready1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_result1: got %0h expected none", {cout1, sum1});
      end else begin
        e = q1.pop_front();
        chk("result_w1", 32'({cout1, sum1}), 32'(e));
        popped1++;
      end
    end
  end

  // Offer one operand set and push its expected result once accepted.
  task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                      input logic [8:0] exp);
    int n;
    n = 0;
    @(negedge clk);
    a = av; b = bv; cin = cv; in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
    end else begin
      q.push_back(exp);
      pushed++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic send1(input logic av, input logic bv, input logic cv, input logic [1:0] exp);
    int n;
    n = 0;
    @(negedge clk);
    a1 = av; b1 = bv; cin1 = cv; in_valid1 = 1'b1;
    while (!in_ready1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready1) begin
      checks++; errors++;
      $display("FAIL accept_timeout1: got in_ready=0 expected 1");
    end else begin
      q1.push_back(exp);
      pushed1++;
    end
    @(posedge clk);
    #1 in_valid1 = 1'b0;
    @(negedge clk);
  endtask

  // Wait until every expected result has been delivered.
  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || q1.size() != 0 || out_valid || out_valid1) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size() + q1.size());
    end
    #3;
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic       rc;
    int         k;
    logic [7:0] dv_a[6] = '{8'hFF, 8'hFF, 8'h80, 8'h00, 8'hA5, 8'h3C};
    logic [7:0] dv_b[6] = '{8'h01, 8'hFF, 8'h80, 8'h00, 8'h5A, 8'hC3};
    logic       dv_c[6] = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1};
    logic [8:0] dv_e[6] = '{9'h100, 9'h1FF, 9'h100, 9'h001, 9'h0FF, 9'h100};
    logic [1:0] fa_e[8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};

    checks = 0; errors = 0; pushed = 0; popped = 0; abandoned = 0;
    pushed1 = 0; popped1 = 0; rand_mode = 1'b0;
    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; out_ready1 = 1'b1;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // Basic add with latency check: result visible after the 8th edge.
    send(8'h0F, 8'h01, 1'b0, 9'h010);
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        k = i;
        break;
      end
    end
    chk("latency", 32'(k), 32'd8);
    drain();

    // Carry ripple and assorted directed vectors.
    for (int i = 0; i < 6; i++) send(dv_a[i], dv_b[i], dv_c[i], dv_e[i]);
    drain();

    // Backpressure in DONE; a new offer must be ignored.
    out_ready = 1'b0;
    send(8'h12, 8'h34, 1'b0, 9'h046);
    k = 0;
    while (!out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        a = 8'h99; b = 8'h99; cin = 1'b1; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_result", 32'({cout, sum}), 32'h046);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    #3;
    chk("bp_no_extra", 32'(q.size()), 32'd0);

    // Reset in the middle of SHIFT after three bits.
    send(8'h01, 8'h02, 1'b0, 9'h003);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_sum", 32'(sum), 32'd0);
    chk("mid_rst_cout", 32'(cout), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    abandoned += q.size();
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h55, 8'hAA, 1'b1, 9'h100);
    drain();

    // WIDTH=1 full-adder truth table, index = {a,b,cin}.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      send1(v[2], v[1], v[0], fa_e[i]);
    end
    drain();

    // Random operands with random consumer stalls.
    rand_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      send(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + 9'(rc));
    end
    @(negedge clk);
    rand_mode = 1'b0;
    out_ready = 1'b1;
    drain();

    chk("count_w8", 32'(popped), 32'(pushed - abandoned));
    chk("count_w1", 32'(popped1), 32'(pushed1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
